operand_loader: RTL
===================

OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 32: input beat width in bits.
REQ-002 SHALL have parameter OPND_W, default 128: operand width in bits; OPND_W/WORD_W (BEATS) SHALL be an integer >= 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port in_data, input, WORD_W: operand beat from the upstream bus.
REQ-006 SHALL have port in_valid, input, 1: in_data valid.
REQ-007 SHALL have port in_ready, output, 1: loader accepts a beat this cycle.
REQ-008 SHALL have port in_parity, input, 1: even-parity bit for in_data.
REQ-009 SHALL have port out_a, output, OPND_W: assembled operand A to the ALU datapath.
REQ-010 SHALL have port out_b, output, OPND_W: assembled operand B to the ALU datapath.
REQ-011 SHALL have port out_valid, output, 1: out_a/out_b form a complete frame.
REQ-012 SHALL have port out_ready, input, 1: ALU consumes the frame.
REQ-013 SHALL have port par_err, output, 1: parity error seen in the current/last frame.

Function
REQ-014 SHALL implement FSM states LOAD_A, LOAD_B and HOLD, plus a beat counter 0..BEATS-1.
REQ-015 SHALL drive in_ready combinationally: 1 in LOAD_A/LOAD_B, 0 in HOLD.
REQ-016 SHALL accept a beat only when in_valid && in_ready; no other cycle changes counter or operand registers.
REQ-017 SHALL write accepted beat k of A into out_a[WORD_W*k +: WORD_W] and beat k of B into out_b[WORD_W*k +: WORD_W], with beat 0 being least significant.
REQ-018 SHALL move LOAD_A->LOAD_B on acceptance of beat BEATS-1 and reset the counter to 0; counter wrap SHALL be exact, with no extra beat.
REQ-019 SHALL move LOAD_B->HOLD on acceptance of beat BEATS-1, with out_valid=1 starting the next cycle (1-cycle latency after the last beat).
REQ-020 SHALL hold out_a, out_b and out_valid stable in HOLD until out_ready=1.
REQ-021 SHALL return HOLD->LOAD_A on out_valid && out_ready, with out_valid=0 and in_ready=1 the next cycle; a beat presented in the handshake cycle SHALL NOT be consumed.
REQ-022 SHALL define out_a/out_b as meaningful only while out_valid=1; partial overwrite during the next frame is permitted.
REQ-023 SHALL achieve minimum frame period 2*BEATS+1 cycles (9 at defaults).

Reset
REQ-024 SHALL, on rst=1 in any state, immediately set state=LOAD_A, counter=0, out_a=0, out_b=0, out_valid=0, par_err=0, discarding any partial frame.
REQ-025 SHALL, after rst deasserts, treat the first accepted beat as beat 0 of A.

Configuration
REQ-026 SHALL, with macro OPERAND_LOADER_PARITY_EN defined, check each accepted beat: ^in_data ^ in_parity != 0 SHALL set par_err=1 the next cycle.
REQ-027 SHALL, with the macro defined, keep par_err sticky through HOLD and clear it on acceptance of the next frame's beat 0 of A, unless that beat also fails.
REQ-028 SHALL complete a frame normally despite parity errors (flag only, no drop).
REQ-029 SHALL, without the macro, tie par_err to 0 and ignore in_parity.

Structure
REQ-030 SHALL place WORD_W/OPND_W defaults, BEATS and the FSM state enum in shared package alu_pkg.
REQ-031 SHALL implement the beat counter with wrap flag as sub-module beat_counter; all else inline.

Verification
REQ-032 SHALL cover: hold rst=1 -> out_valid=0, out_a=out_b=0, par_err=0; after release in_ready=1.
REQ-033 SHALL cover: A beats 0x11111111..0x44444444, B beats 0xAAAA0000..0xDDDD0000, back-to-back -> out_valid=1 one cycle after the 8th beat, out_a=0x44444444_33333333_22222222_11111111, out_b=0xDDDD0000_CCCC0000_BBBB0000_AAAA0000.
REQ-034 SHALL cover: out_ready=0 for 5 cycles in HOLD with in_valid=1 -> outputs stable, in_ready=0, no beat consumed; out_ready=1 -> in_ready=1 next cycle.
REQ-035 SHALL cover: in_valid toggling every other cycle -> same frame as REQ-033 after 16 cycles, no dropped or duplicated beats.
REQ-036 SHALL cover: rst pulsed after 5 accepted beats -> all outputs 0; the next 8 beats form a correct frame.
REQ-037 SHALL cover, with OPERAND_LOADER_PARITY_EN: beat 2 with in_data=0x00000001, in_parity=0 -> par_err=1 next cycle, held through HOLD, cleared by a good beat 0 of the next frame.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: default operand-loader widths, beats per operand and the loader FSM states.
package alu_pkg;
   localparam int WORD_W_DEF = 32;
   localparam int OPND_W_DEF = 128;
   localparam int BEATS = OPND_W_DEF / WORD_W_DEF;
   typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} state_t;
endpackage

// File: rtl/beat_counter.sv
// beat_counter: modulo-N beat index; wrap flags the accepted beat that completes an operand.
module beat_counter #(
   parameter int N = 4,
   parameter int CW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   output logic [CW-1:0] cnt,
   output logic          wrap
);
   assign wrap = inc && cnt == CW'(N - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (inc) cnt <= wrap ? '0 : cnt + 1'b1;
endmodule

// File: rtl/operand_loader.sv
// operand_loader: assembles two OPND_W operands from WORD_W beats and holds them for the ALU.
// Optional beat parity checking is enabled by defining OPERAND_LOADER_PARITY_EN.
module operand_loader
   import alu_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int OPND_W = OPND_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_parity,
   output logic [OPND_W-1:0] out_a,
   output logic [OPND_W-1:0] out_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              par_err
);
   localparam int NB = OPND_W / WORD_W;
   localparam int CW = $clog2(NB);
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic wrap, accept;
   assign in_ready = state != HOLD;
   assign out_valid = state == HOLD;
   assign accept = in_valid && in_ready;
   beat_counter #(.N(NB), .CW(CW)) u_cnt (
      .clk(clk),
      .rst(rst),
      .inc(accept),
      .cnt(cnt),
      .wrap(wrap)
   );
   always_comb begin
      state_nx = state;
      case (state)
         LOAD_A:  state_nx = wrap ? LOAD_B : LOAD_A;
         LOAD_B:  state_nx = wrap ? HOLD : LOAD_B;
         HOLD:    state_nx = out_ready ? LOAD_A : HOLD;
         default: state_nx = LOAD_A;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= LOAD_A;
         out_a <= '0;
         out_b <= '0;
      end else begin
         state <= state_nx;
         if (accept && state == LOAD_A) out_a[WORD_W*int'(cnt) +: WORD_W] <= in_data;
         if (accept && state == LOAD_B) out_b[WORD_W*int'(cnt) +: WORD_W] <= in_data;
      end
`ifdef OPERAND_LOADER_PARITY_EN
   logic bad;
   assign bad = ^in_data ^ in_parity;
   // beat 0 of A starts a fresh frame, so it overwrites rather than accumulates
   always_ff @(posedge clk or posedge rst)
      if (rst) par_err <= 1'b0;
      else if (accept) par_err <= (state == LOAD_A && cnt == '0) ? bad : (par_err | bad);
`else
   logic unused_parity;
   assign unused_parity = in_parity;
   assign par_err = 1'b0;
`endif
endmodule
